instruction_fetch_unit: RTL and testbench

//  Producer side of the decoder's instruction interface: owns the fetch PC, reads 16-bit

---
 rtl/xm_pkg.sv | 26 ++
 rtl/ifu_fifo.sv | 60 ++++++
 rtl/instruction_fetch_unit.sv | 140 ++++++++++++++
 tb/tb_instruction_fetch_unit.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/xm_pkg.sv
// Shared types for the instruction fetch unit.
// Buffer depth follows IFU_PREFETCH_EN (2 when defined, else 1).
package xm_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    DRAIN = 2'd2
  } ifu_state_t;

  localparam int INST_W  = 16;
  localparam int PC_STEP = 2;
  localparam int IFU_AW  = 16;

`ifdef IFU_PREFETCH_EN
  localparam int IFU_DEPTH = 2;
`else
  localparam int IFU_DEPTH = 1;
`endif

  typedef struct packed {
    logic [INST_W-1:0] inst;
    logic [IFU_AW-1:0] pc;
  } fetch_entry_t;

endpackage

// File: rtl/ifu_fifo.sv
// Fetch buffer of depth 1 or 2 with flush; head is combinational.
// Depth comes from IFU_PREFETCH_EN via xm_pkg.
module ifu_fifo
  import xm_pkg::*;
#(
  parameter int DEPTH = IFU_DEPTH
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         i_push,
  input  logic         i_pop,
  input  logic         i_flush,
  input  fetch_entry_t i_wdata,
  output fetch_entry_t o_head,
  output logic         o_empty,
  output logic [1:0]   o_count
);

  localparam logic [1:0] DEPTH_C = 2'(DEPTH);

  fetch_entry_t r_mem [2];
  logic         r_wp;
  logic         r_rp;
  logic [1:0]   r_cnt;
  logic         w_full;
  logic         w_push;
  logic         w_pop;

  function automatic logic nxt(input logic p);
    return (DEPTH == 1) ? 1'b0 : ~p;
  endfunction

  assign w_full  = (r_cnt == DEPTH_C);
  assign w_pop   = i_pop & (r_cnt != 2'd0);
  assign w_push  = i_push & (~w_full | w_pop);
  assign o_empty = (r_cnt == 2'd0);
  assign o_count = r_cnt;
  assign o_head  = o_empty ? '0 : r_mem[r_rp];

  // Pointer and occupancy tracking; flush empties in one cycle.
  always_ff @(posedge clk) begin
    if (reset | i_flush) begin
      r_wp  <= 1'b0;
      r_rp  <= 1'b0;
      r_cnt <= 2'd0;
    end else begin
      if (w_push) r_wp <= nxt(r_wp);
      if (w_pop)  r_rp <= nxt(r_rp);
      r_cnt <= r_cnt + {1'b0, w_push}
                     - {1'b0, w_pop};
    end
  end

  // Entry storage; contents are don't-care while empty.
  always_ff @(posedge clk) begin
    if (w_push & ~reset & ~i_flush)
      r_mem[r_wp] <= i_wdata;
  end

endmodule

// File: rtl/instruction_fetch_unit.sv
// Fetch PC, imem req/ack FSM and buffering toward the decoder.
// IFU_PREFETCH_EN selects a 2-deep prefetch buffer (default 1).
module instruction_fetch_unit
  import xm_pkg::*;
#(
  parameter int          ADDR_W       = 16,
  parameter logic [15:0] RESET_VECTOR = 16'h0000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              redirect_en,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [15:0]       imem_rdata,
  output logic              inst_valid,
  output logic [15:0]       inst_data,
  output logic [ADDR_W-1:0] inst_pc,
  input  logic              dec_take,
  output logic              dec_en
);

  localparam logic [ADDR_W-1:0] EVEN =
    ~ADDR_W'(1);
  localparam logic [ADDR_W-1:0] RV =
    ADDR_W'(RESET_VECTOR) & EVEN;
  localparam logic [ADDR_W-1:0] STEP =
    ADDR_W'(PC_STEP);
  localparam logic [1:0] DEPTH_C =
    2'(IFU_DEPTH);

  ifu_state_t        r_state;
  logic              r_req;
  logic [ADDR_W-1:0] r_fetch_pc;
  logic [ADDR_W-1:0] r_addr;

  logic              w_ack;
  logic              w_push;
  logic              w_pop;
  logic              w_empty;
  logic              w_slot_free;
  logic [1:0]        w_count;
  logic [1:0]        w_cnt_after;
  logic [ADDR_W-1:0] w_redir_pc;
  logic [ADDR_W-1:0] w_pc_inc;
  fetch_entry_t      w_wentry;
  fetch_entry_t      w_head;

  assign w_redir_pc = redirect_pc & EVEN;
  assign w_pc_inc   = r_fetch_pc + STEP;
  assign w_ack      = r_req & imem_ack;
  assign w_push     = (r_state == REQ)
                    & imem_ack
                    & ~redirect_en;
  assign w_pop      = ~w_empty & dec_take
                    & ~redirect_en;

  // Occupancy after this cycle decides
  // whether another request may issue.
  assign w_cnt_after = w_count
                     + {1'b0, w_push}
                     - {1'b0, w_pop};
  assign w_slot_free = (w_cnt_after < DEPTH_C);

  assign w_wentry.inst = imem_rdata;
  assign w_wentry.pc   = r_addr;

  ifu_fifo #(
    .DEPTH (IFU_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_flush (redirect_en),
    .i_wdata (w_wentry),
    .o_head  (w_head),
    .o_empty (w_empty),
    .o_count (w_count)
  );

  // Request FSM; r_addr holds the in-flight
  // address through DRAIN while fetch_pc moves.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= IDLE;
      r_req      <= 1'b0;
      r_fetch_pc <= RV;
      r_addr     <= RV;
    end else if (redirect_en) begin
      r_fetch_pc <= w_redir_pc;
      if ((r_state != IDLE) & ~w_ack) begin
        r_state <= DRAIN;
        r_req   <= 1'b1;
      end else begin
        r_state <= IDLE;
        r_req   <= 1'b0;
        r_addr  <= w_redir_pc;
      end
    end else begin
      unique case (r_state)
        IDLE: begin
          if (w_slot_free) begin
            r_state <= REQ;
            r_req   <= 1'b1;
          end
        end
        REQ: begin
          if (w_ack) begin
            r_fetch_pc <= w_pc_inc;
            r_addr     <= w_pc_inc;
            if (!w_slot_free) begin
              r_state <= IDLE;
              r_req   <= 1'b0;
            end
          end
        end
        DRAIN: begin
          if (w_ack) begin
            r_state <= REQ;
            r_addr  <= r_fetch_pc;
          end
        end
        default: begin
          r_state <= IDLE;
          r_req   <= 1'b0;
        end
      endcase
    end
  end

  assign imem_req   = r_req;
  assign imem_addr  = r_addr;
  assign inst_valid = ~w_empty;
  assign inst_data  = w_head.inst;
  assign inst_pc    = w_head.pc;
  assign dec_en     = w_pop;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Randomized scoreboard bench for instruction_fetch_unit.
// Expected buffer depth follows IFU_PREFETCH_EN.
module tb_instruction_fetch_unit;

  localparam logic [15:0] RV = 16'h0000;
`ifdef IFU_PREFETCH_EN
  localparam int DEPTH = 2;
`else
  localparam int DEPTH = 1;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        redirect_en = 1'b0;
  logic [15:0] redirect_pc = '0;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [15:0] imem_rdata = '0;
  logic        inst_valid;
  logic [15:0] inst_data;
  logic [15:0] inst_pc;
  logic        dec_take = 1'b0;
  logic        dec_en;

  instruction_fetch_unit #(
    .ADDR_W       (16),
    .RESET_VECTOR (RV)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .redirect_en (redirect_en),
    .redirect_pc (redirect_pc),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_rdata  (imem_rdata),
    .inst_valid  (inst_valid),
    .inst_data   (inst_data),
    .inst_pc     (inst_pc),
    .dec_take    (dec_take),
    .dec_en      (dec_en)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0] pc;
    logic [15:0] data;
  } exp_t;

  exp_t        q[$];
  int          n_vec = 0;
  int          n_err = 0;
  int          n_pop = 0;
  logic        pending = 1'b0;
  logic        stale = 1'b0;
  logic        post_rst = 1'b0;
  logic        ack_done;
  logic [15:0] exp_fetch = RV;
  logic [15:0] req_addr = '0;

  function automatic logic [15:0] mem_word(
    input logic [15:0] a);
    return (a ^ 16'hC3A5) + {a[7:0], a[15:8]};
  endfunction

  task automatic chk(input string name,
                     input logic [15:0] act,
                     input logic [15:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h @%0t",
               name, act, exp, $time);
    end
  endtask

  // Reference model and monitor: the queue is the
  // expected buffer content at the start of each cycle.
  always @(negedge clk) begin
    if (reset) begin
      q.delete();
      pending   = 1'b0;
      stale     = 1'b0;
      exp_fetch = RV;
      post_rst  = 1'b1;
    end else begin
      if (post_rst) begin
        chk("rst_req", imem_req, 0);
        chk("rst_valid", inst_valid, 0);
        chk("rst_data", inst_data, 0);
        chk("rst_pc", inst_pc, 0);
        chk("rst_dec_en", dec_en, 0);
        post_rst = 1'b0;
      end
      chk("inst_valid", inst_valid, q.size() != 0);
      if (inst_valid && q.size() != 0) begin
        chk("inst_pc", inst_pc, q[0].pc);
        chk("inst_data", inst_data, q[0].data);
      end
      chk("dec_en", dec_en,
          inst_valid & dec_take & ~redirect_en);
      if (pending) begin
        chk("req_hold", imem_req, 1);
        chk("addr_hold", imem_addr, req_addr);
      end else if (imem_req) begin
        chk("imem_addr", imem_addr, exp_fetch);
        chk("room", q.size() < DEPTH, 1);
        pending  = 1'b1;
        stale    = 1'b0;
        req_addr = imem_addr;
      end
      ack_done = pending && imem_req && imem_ack;
      if (redirect_en) begin
        q.delete();
        exp_fetch = redirect_pc & 16'hFFFE;
        if (pending && !ack_done) stale = 1'b1;
      end else if (dec_en && q.size() != 0) begin
        void'(q.pop_front());
        n_pop++;
      end
      if (ack_done) begin
        if (!stale && !redirect_en) begin
          q.push_back('{pc: req_addr,
                        data: mem_word(req_addr)});
          exp_fetch = req_addr + 16'd2;
        end
        pending = 1'b0;
      end
    end
  end

  task automatic cyc(input logic ack,
                     input logic take,
                     input logic redir,
                     input logic [15:0] rpc,
                     input logic rst);
    @(posedge clk);
    #1;
    imem_ack    = ack;
    dec_take    = take;
    redirect_en = redir;
    redirect_pc = rpc;
    reset       = rst;
    imem_rdata  = mem_word(imem_addr);
  endtask

  task automatic wait_req(input int lim);
    int k;
    k = 0;
    while (imem_req !== 1'b1 && k < lim) begin
      cyc(1'b0, 1'b1, 1'b0, 16'h0, 1'b0);
      k++;
    end
    chk("wait_req", imem_req, 1);
  endtask

  // Stimulus: directed scenarios, then random traffic.
  initial begin
    repeat (3) cyc(0, 0, 0, 16'h0, 1);
    repeat (40) cyc(1, 1, 0, 16'h0, 0);
    repeat (10) cyc(1, 0, 0, 16'h0, 0);
    chk("stall_req", imem_req, 0);
    chk("stall_valid", inst_valid, 1);
    repeat (20) cyc(1, 1, 0, 16'h0, 0);
    wait_req(10);
    cyc(0, 1, 1, 16'h0101, 0);
    cyc(0, 1, 0, 16'h0, 0);
    cyc(0, 1, 0, 16'h0, 0);
    cyc(1, 1, 0, 16'h0, 0);
    repeat (20) cyc(1, 1, 0, 16'h0, 0);
    cyc(1, 1, 1, 16'hFFFC, 0);
    repeat (12) cyc(1, 1, 0, 16'h0, 0);
    cyc(1, 1, 1, 16'h4000, 0);
    repeat (8) cyc(1, 1, 0, 16'h0, 0);
    wait_req(10);
    cyc(0, 1, 0, 16'h0, 1);
    cyc(1, 1, 0, 16'h0, 0);
    chk("stale_ack_req", imem_req, 0);
    repeat (12) cyc(1, 1, 0, 16'h0, 0);
    for (int i = 0; i < 3000; i++) begin
      logic [15:0] t;
      int          r;
      r = $urandom_range(0, 99);
      t = 16'($urandom);
      if (r < 5)       t = 16'hFFFE;
      else if (r < 10) t = 16'h0101;
      cyc($urandom_range(0, 99) < 60,
          $urandom_range(0, 99) < 70,
          $urandom_range(0, 99) < 4,
          t,
          $urandom_range(0, 999) < 4);
    end
    cyc(0, 0, 0, 16'h0, 0);
    cyc(0, 0, 0, 16'h0, 0);
    chk("progress", n_pop > 100, 1);
    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule
